id_stage_fwd: RTL and testbench
===============================

Name: id_stage_fwd

Overview:
Parametrised decode stage with an integrated ID/EX pipeline register. It decodes the logic and shift subset of the ISA and reads rs/rt from the regfile. Operands are resolved through a priority bypass network fed by NUM_FWD later pipeline stages. It detects load-use hazards, requests a stall and inserts bubbles. It sits between the IF/ID register and EX.

Parameters:
DATA_W, 32, datapath width; must be >= 32.
NUM_FWD, 2, number of bypass sources; index 0 is youngest (EX), higher index is older.
REG_AW, 5, register address width.

Ports:
clk  in  1  clock; one clock domain.
rst  in  1  reset; synchronous, active-high.
pc_i  in  32  PC of the instruction in ID.
inst_i  in  32  instruction word.
inst_valid_i  in  1  inst_i is valid; 0 decodes as bubble.
reg1_data_i, reg2_data_i  in  DATA_W  regfile read data.
fwd_wreg_i  in  NUM_FWD  per-source write enable.
fwd_wd_i  in  NUM_FWD*REG_AW  per-source destination, packed, source k at [k*REG_AW +: REG_AW].
fwd_wdata_i  in  NUM_FWD*DATA_W  per-source result, packed.
fwd_load_i  in  NUM_FWD  per-source result not yet available (load in flight).
ex_stall_i  in  1  EX cannot accept; hold ID/EX.
flush_i  in  1  kill ID/EX contents.
reg1_read_o, reg2_read_o  out  1  combinational read enables.
reg1_addr_o, reg2_addr_o  out  REG_AW  combinational read addresses.
stallreq_o  out  1  combinational load-use stall request to pipeline control.
ex_valid_o  out  1  registered; ID/EX holds a real instruction.
ex_aluop_o  out  8  registered ALU subtype.
ex_alusel_o  out  3  registered ALU result type.
ex_reg1_o, ex_reg2_o  out  DATA_W  registered resolved operands.
ex_wd_o  out  REG_AW  registered destination.
ex_wreg_o  out  1  registered write enable.
ex_pc_o  out  32  registered PC.

Behaviour:
- Decode (combinational):
  - ORI 0x0D, ANDI 0x0C, XORI 0x0E: rs read, imm zero-extended to DATA_W, wd=rt.
  - LUI 0x0F: no reg read, imm in bits [DATA_W-1:DATA_W-16], lower bits zero, wd=rt.
  - SPECIAL 0x00, func AND 0x24 / OR 0x25 / XOR 0x26 / NOR 0x27: read rs and rt, wd=rd.
  - SPECIAL 0x00, func SLL 0x00 / SRL 0x02 / SRA 0x03: reg1 = sa zero-extended, read rt, wd=rd.
  - Any other opcode/func: NOP (aluop EXE_NOP_OP, alusel EXE_RES_NOP, no reads, wreg=0).
  - A disabled read port drives address 0.
  - wreg is forced to 0 when wd==0.
- Operand resolution, per operand:
  - Read disabled -> imm.
  - Address 0 -> 0; never forwarded.
  - Otherwise the lowest index k with fwd_wreg_i[k]=1 and fwd_wd_i[k]==addr wins and supplies fwd_wdata_i[k].
  - No match -> regfile data.
- Load-use:
  - stallreq_o=1 if any enabled nonzero read address has its winning (lowest-index) match with fwd_load_i[k]=1.
  - An older matching source never masks a younger load.
- ID/EX register, priority order on each clk edge:
  1. rst: all ex_* outputs = 0.
  2. flush_i: bubble (ex_valid_o=0, wreg=0, aluop/alusel NOP, operands 0).
  3. ex_stall_i: hold all ex_* outputs.
  4. stallreq_o or !inst_valid_i: bubble.
  5. Otherwise capture the decoded and resolved values, with ex_valid_o=1.
- Latency: 1 cycle ID to EX. A stalled instruction re-resolves its operands every cycle until stallreq_o drops.
- While rst=1: reg*_read_o=0, addrs=0, stallreq_o=0.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [31:0], a registered counter.
  - Increments on every cycle with stallreq_o=1 and ex_stall_i=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst; not cleared by flush_i.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- The shared defines include holds:
  - opcode and func constants;
  - EXE_*_OP and EXE_RES_* codes;
  - RstEnable=1, ReadEnable, WriteEnable, ZeroWord, NOPRegAddr.
- One sub-module, id_fwd_mux: parametrised priority bypass for a single operand. Outputs the operand value and a load-hit flag. Instantiated twice.

Test Plan:
- rst=1 for 2 cycles with inst ORI -> all ex_* = 0, stallreq_o=0. After release, ORI r2,r1,0x00FF with r1=0x12340000 -> next cycle ex_reg1_o=0x12340000, ex_reg2_o=0x000000FF, ex_wd_o=2, ex_aluop_o=EXE_OR_OP.
- OR r3,r1,r2; fwd[0] wd=1 data=0xAAAA0000; fwd[1] wd=1 data=0x11111111 and wd=2 -> ex_reg1_o=0xAAAA0000 (youngest wins), ex_reg2_o=fwd[1] data.
- Forwarding into address 0: ADD-free OR r4,r0,r2 with fwd[0] wd=0 wreg=1 data=0xFFFFFFFF -> ex_reg1_o=0.
- Load-use: ANDI r5,r6,1 with fwd[0] wd=6 fwd_load_i[0]=1 -> stallreq_o=1, ex_valid_o=0 next cycle. Next cycle load moves to fwd[1], fwd_load_i=0 data=0x7 -> capture with ex_reg1_o=0x7.
- ex_stall_i=1 for 3 cycles during a valid LUI r7,0xBEEF -> ex_reg2_o stays 0xBEEF0000. A flush_i during the stall -> bubble next edge.
- With ID_STALL_CNT_EN: 5 load-use cycles, 2 of them with ex_stall_i=1 -> stall_cnt_o=3.

Source files
------------

// File: rtl/id_stage_fwd_pkg.sv
// id_stage_fwd_pkg
// Shared constants for the decode stage: opcode/func encodings of the
// logic and shift subset, ALU subtype (EXE_*_OP) and result-type
// (EXE_RES_*) codes, and generic enable/zero constants.
package id_stage_fwd_pkg;

    // Generic control constants
    localparam logic        RstEnable    = 1'b1;
    localparam logic        ReadEnable   = 1'b1;
    localparam logic        ReadDisable  = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    // Primary opcodes
    localparam logic [5:0] EXE_SPECIAL = 6'h00;
    localparam logic [5:0] EXE_ANDI    = 6'h0C;
    localparam logic [5:0] EXE_ORI     = 6'h0D;
    localparam logic [5:0] EXE_XORI    = 6'h0E;
    localparam logic [5:0] EXE_LUI     = 6'h0F;

    // SPECIAL func codes
    localparam logic [5:0] EXE_SLL = 6'h00;
    localparam logic [5:0] EXE_SRL = 6'h02;
    localparam logic [5:0] EXE_SRA = 6'h03;
    localparam logic [5:0] EXE_AND = 6'h24;
    localparam logic [5:0] EXE_OR  = 6'h25;
    localparam logic [5:0] EXE_XOR = 6'h26;
    localparam logic [5:0] EXE_NOR = 6'h27;

    // ALU subtype
    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;

    // ALU result type
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux
// Priority bypass for one source operand.
//   read_en     : operand comes from the register file (else imm is used)
//   addr        : register address being read
//   rf_data     : register file read data
//   imm         : decoded immediate, used when read_en=0
//   fwd_*       : NUM_FWD bypass sources, index 0 youngest
//   data        : resolved operand
//   load_hit    : the winning bypass source still has a load in flight
module id_fwd_mux
    import id_stage_fwd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
) (
    input  logic                      read_en,
    input  logic [REG_AW-1:0]         addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [DATA_W-1:0]         imm,
    input  logic [NUM_FWD-1:0]        fwd_wreg,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_load,
    output logic [DATA_W-1:0]         data,
    output logic                      load_hit
);

    always_comb begin
        data     = imm;
        load_hit = 1'b0;
        if (read_en == ReadEnable) begin
            if (addr == '0) begin
                // r0 is hardwired; a write to it must never be bypassed
                data = '0;
            end else begin
                data = rf_data;
                // Walk oldest to youngest so the youngest match overwrites;
                // load_hit follows the same winner so an older match can
                // never hide a younger load.
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (fwd_wreg[k] && (fwd_wd[k*REG_AW +: REG_AW] == addr)) begin
                        data     = fwd_wdata[k*DATA_W +: DATA_W];
                        load_hit = fwd_load[k];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/id_stage_fwd.sv
// id_stage_fwd
// Decode stage for the logic/shift subset with the ID/EX pipeline
// register. Operands are resolved through a priority bypass network
// (id_fwd_mux, one per operand); load-use hazards raise stallreq_o and
// insert bubbles into EX.
// Optional feature (macro ID_STALL_CNT_EN): stall_cnt_o, a saturating
// count of cycles spent stalled on load-use while EX was accepting.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   pc_i, inst_i,
//   inst_valid_i           : instruction in ID
//   reg1/2_data_i          : regfile read data
//   fwd_*_i                : bypass sources (index 0 youngest)
//   ex_stall_i, flush_i    : pipeline control into ID/EX
//   reg1/2_read_o/addr_o   : combinational regfile read port control
//   stallreq_o             : combinational load-use stall request
//   ex_*_o                 : registered ID/EX contents
module id_stage_fwd
    import id_stage_fwd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc_i,
    input  logic [31:0]               inst_i,
    input  logic                      inst_valid_i,
    input  logic [DATA_W-1:0]         reg1_data_i,
    input  logic [DATA_W-1:0]         reg2_data_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_load_i,
    input  logic                      ex_stall_i,
    input  logic                      flush_i,
    output logic                      reg1_read_o,
    output logic                      reg2_read_o,
    output logic [REG_AW-1:0]         reg1_addr_o,
    output logic [REG_AW-1:0]         reg2_addr_o,
    output logic                      stallreq_o,
    output logic                      ex_valid_o,
    output logic [7:0]                ex_aluop_o,
    output logic [2:0]                ex_alusel_o,
    output logic [DATA_W-1:0]         ex_reg1_o,
    output logic [DATA_W-1:0]         ex_reg2_o,
    output logic [REG_AW-1:0]         ex_wd_o,
    output logic                      ex_wreg_o,
    output logic [31:0]               ex_pc_o
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);

    // Instruction fields
    logic [5:0]        opcode, func;
    logic [REG_AW-1:0] rs_a, rt_a, rd_a;
    logic [4:0]        sa;

    assign opcode = inst_i[31:26];
    assign rs_a   = REG_AW'(inst_i[25:21]);
    assign rt_a   = REG_AW'(inst_i[20:16]);
    assign rd_a   = REG_AW'(inst_i[15:11]);
    assign sa     = inst_i[10:6];
    assign func   = inst_i[5:0];

    // Decoded controls
    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic              rd1_en, rd2_en;
    logic [REG_AW-1:0] dec_wd;
    logic              dec_wreg_raw, dec_wreg;
    logic [DATA_W-1:0] imm;

    always_comb begin
        dec_aluop    = EXE_NOP_OP;
        dec_alusel   = EXE_RES_NOP;
        rd1_en       = ReadDisable;
        rd2_en       = ReadDisable;
        dec_wd       = '0;
        dec_wreg_raw = WriteDisable;
        imm          = '0;
        // Reset and invalid slots decode as NOP: no reads means no stall.
        if (!rst && inst_valid_i) begin
            case (opcode)
                EXE_ORI, EXE_ANDI, EXE_XORI: begin
                    rd1_en       = ReadEnable;
                    imm          = {{(DATA_W-16){1'b0}}, inst_i[15:0]};
                    dec_wd       = rt_a;
                    dec_wreg_raw = WriteEnable;
                    dec_alusel   = EXE_RES_LOGIC;
                    dec_aluop    = (opcode == EXE_ORI)  ? EXE_OR_OP  :
                                   (opcode == EXE_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
                end
                EXE_LUI: begin
                    // Both operands take the shifted immediate; OR yields it.
                    imm          = {inst_i[15:0], {(DATA_W-16){1'b0}}};
                    dec_wd       = rt_a;
                    dec_wreg_raw = WriteEnable;
                    dec_alusel   = EXE_RES_LOGIC;
                    dec_aluop    = EXE_OR_OP;
                end
                EXE_SPECIAL: begin
                    case (func)
                        EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
                            rd1_en       = ReadEnable;
                            rd2_en       = ReadEnable;
                            dec_wd       = rd_a;
                            dec_wreg_raw = WriteEnable;
                            dec_alusel   = EXE_RES_LOGIC;
                            case (func)
                                EXE_AND: dec_aluop = EXE_AND_OP;
                                EXE_OR:  dec_aluop = EXE_OR_OP;
                                EXE_XOR: dec_aluop = EXE_XOR_OP;
                                default: dec_aluop = EXE_NOR_OP;
                            endcase
                        end
                        EXE_SLL, EXE_SRL, EXE_SRA: begin
                            // Shift amount rides on operand 1 via imm.
                            rd2_en       = ReadEnable;
                            imm          = DATA_W'(sa);
                            dec_wd       = rd_a;
                            dec_wreg_raw = WriteEnable;
                            dec_alusel   = EXE_RES_SHIFT;
                            case (func)
                                EXE_SLL: dec_aluop = EXE_SLL_OP;
                                EXE_SRL: dec_aluop = EXE_SRL_OP;
                                default: dec_aluop = EXE_SRA_OP;
                            endcase
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign dec_wreg    = dec_wreg_raw && (dec_wd != '0);
    assign reg1_read_o = rd1_en;
    assign reg2_read_o = rd2_en;
    assign reg1_addr_o = rd1_en ? rs_a : '0;
    assign reg2_addr_o = rd2_en ? rt_a : '0;

    // Operand resolution
    logic [DATA_W-1:0] op1, op2;
    logic              hit1, hit2;

    id_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) u_op1 (
        .read_en   (rd1_en),
        .addr      (reg1_addr_o),
        .rf_data   (reg1_data_i),
        .imm       (imm),
        .fwd_wreg  (fwd_wreg_i),
        .fwd_wd    (fwd_wd_i),
        .fwd_wdata (fwd_wdata_i),
        .fwd_load  (fwd_load_i),
        .data      (op1),
        .load_hit  (hit1)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) u_op2 (
        .read_en   (rd2_en),
        .addr      (reg2_addr_o),
        .rf_data   (reg2_data_i),
        .imm       (imm),
        .fwd_wreg  (fwd_wreg_i),
        .fwd_wd    (fwd_wd_i),
        .fwd_wdata (fwd_wdata_i),
        .fwd_load  (fwd_load_i),
        .data      (op2),
        .load_hit  (hit2)
    );

    assign stallreq_o = hit1 | hit2;

    // ID/EX register
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ex_valid_o  <= 1'b0;
            ex_aluop_o  <= '0;
            ex_alusel_o <= '0;
            ex_reg1_o   <= '0;
            ex_reg2_o   <= '0;
            ex_wd_o     <= '0;
            ex_wreg_o   <= 1'b0;
            ex_pc_o     <= '0;
        end else if (flush_i || (!ex_stall_i && (stallreq_o || !inst_valid_i))) begin
            ex_valid_o  <= 1'b0;
            ex_aluop_o  <= EXE_NOP_OP;
            ex_alusel_o <= EXE_RES_NOP;
            ex_reg1_o   <= '0;
            ex_reg2_o   <= '0;
            ex_wd_o     <= '0;
            ex_wreg_o   <= WriteDisable;
            ex_pc_o     <= '0;
        end else if (!ex_stall_i) begin
            ex_valid_o  <= 1'b1;
            ex_aluop_o  <= dec_aluop;
            ex_alusel_o <= dec_alusel;
            ex_reg1_o   <= op1;
            ex_reg2_o   <= op2;
            ex_wd_o     <= dec_wd;
            ex_wreg_o   <= dec_wreg;
            ex_pc_o     <= pc_i;
        end
    end

`ifdef ID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            stall_cnt_o <= '0;
        else if (stallreq_o && !ex_stall_i && (stall_cnt_o != 32'hFFFF_FFFF))
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_id_stage_fwd.sv
// tb_id_stage_fwd
// Directed vectors for id_stage_fwd. Each stimulus cycle pushes the
// hand-computed ID/EX contents expected after the next edge; a monitor
// pops and compares one entry after every rising edge.
module tb_id_stage_fwd;

    localparam int DW = 32;
    localparam int NF = 2;
    localparam int AW = 5;

    localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR  = 8'h25,
                           OP_NOR = 8'h27, OP_SLL = 8'h7C, OP_SRA = 8'h03;
    localparam logic [2:0] RS_NOP = 3'd0, RS_LOGIC = 3'd1, RS_SHIFT = 3'd2;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       pc, inst;
    logic              inst_valid;
    logic [DW-1:0]     reg1_data, reg2_data;
    logic [NF-1:0]     fwd_wreg, fwd_load;
    logic [NF*AW-1:0]  fwd_wd;
    logic [NF*DW-1:0]  fwd_wdata;
    logic              ex_stall, flush;
    logic              reg1_read, reg2_read, stallreq;
    logic [AW-1:0]     reg1_addr, reg2_addr;
    logic              ex_valid, ex_wreg;
    logic [7:0]        ex_aluop;
    logic [2:0]        ex_alusel;
    logic [DW-1:0]     ex_reg1, ex_reg2;
    logic [AW-1:0]     ex_wd;
    logic [31:0]       ex_pc;
`ifdef ID_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    id_stage_fwd #(.DATA_W(DW), .NUM_FWD(NF), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .pc_i(pc), .inst_i(inst), .inst_valid_i(inst_valid),
        .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
        .fwd_wreg_i(fwd_wreg), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata),
        .fwd_load_i(fwd_load), .ex_stall_i(ex_stall), .flush_i(flush),
        .reg1_read_o(reg1_read), .reg2_read_o(reg2_read),
        .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr), .stallreq_o(stallreq),
        .ex_valid_o(ex_valid), .ex_aluop_o(ex_aluop), .ex_alusel_o(ex_alusel),
        .ex_reg1_o(ex_reg1), .ex_reg2_o(ex_reg2), .ex_wd_o(ex_wd),
        .ex_wreg_o(ex_wreg), .ex_pc_o(ex_pc)
`ifdef ID_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       valid;
        logic [7:0] aluop;
        logic [2:0] alusel;
        logic [31:0] r1, r2;
        logic [4:0] wd;
        logic       wreg;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic v, input logic [7:0] op,
                                input logic [2:0] sel, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [4:0] wd, input logic wr);
        exp_t e;
        e.nm = nm; e.valid = v; e.aluop = op; e.alusel = sel;
        e.r1 = r1; e.r2 = r2; e.wd = wd; e.wreg = wr;
        return e;
    endfunction

    function automatic exp_t bubble(input string nm);
        return mk(nm, 1'b0, OP_NOP, RS_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    endfunction

    function automatic exp_t held(input string nm);
        exp_t e;
        e = cur;
        e.nm = nm;
        return e;
    endfunction

    // Inputs are already driven (at a negedge); check the combinational
    // stall request, queue the expectation, then run through one edge.
    task automatic step(input exp_t e, input logic exp_stall);
        #1;
        cmp({e.nm, ".stallreq"}, 32'(stallreq), 32'(exp_stall));
        q.push_back(e);
        cur = e;
        @(negedge clk);
    endtask

    task automatic set_fwd(input int k, input logic wr, input logic [4:0] wd,
                           input logic [31:0] d, input logic ld);
        fwd_wreg[k]            = wr;
        fwd_wd[k*AW +: AW]     = wd;
        fwd_wdata[k*DW +: DW]  = d;
        fwd_load[k]            = ld;
    endtask

    task automatic clr_fwd();
        fwd_wreg = '0; fwd_wd = '0; fwd_wdata = '0; fwd_load = '0;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp({e.nm, ".valid"},  32'(ex_valid),  32'(e.valid));
                cmp({e.nm, ".aluop"},  32'(ex_aluop),  32'(e.aluop));
                cmp({e.nm, ".alusel"}, 32'(ex_alusel), 32'(e.alusel));
                cmp({e.nm, ".reg1"},   ex_reg1,        e.r1);
                cmp({e.nm, ".reg2"},   ex_reg2,        e.r2);
                cmp({e.nm, ".wd"},     32'(ex_wd),     32'(e.wd));
                cmp({e.nm, ".wreg"},   32'(ex_wreg),   32'(e.wreg));
            end
        end
    end

    initial begin
`ifdef ID_STALL_CNT_EN
        logic [31:0] cnt0;
`endif
        rst = 1'b1; pc = 32'h0000_1000; inst = 32'h3422_00FF; inst_valid = 1'b1;
        reg1_data = 32'h1234_0000; reg2_data = 32'h0000_BEEF;
        ex_stall = 1'b0; flush = 1'b0;
        clr_fwd();

        // Reset
        step(bubble("rst0"), 1'b0);
        cmp("rst.reg1_read", 32'(reg1_read), 32'h0);
        cmp("rst.reg1_addr", 32'(reg1_addr), 32'h0);
        step(bubble("rst1"), 1'b0);
        rst = 1'b0;

        // ORI r2,r1,0x00FF
        #1;
        cmp("ori.reg1_read", 32'(reg1_read), 32'h1);
        cmp("ori.reg1_addr", 32'(reg1_addr), 32'h1);
        cmp("ori.reg2_read", 32'(reg2_read), 32'h0);
        step(mk("ori", 1, OP_OR, RS_LOGIC, 32'h1234_0000, 32'h0000_00FF, 5'd2, 1), 1'b0);

        // OR r3,r1,r2: both sources hit r1, youngest wins
        inst = 32'h0022_1825;
        set_fwd(0, 1, 5'd1, 32'hAAAA_0000, 0);
        set_fwd(1, 1, 5'd1, 32'h1111_1111, 0);
        step(mk("or_young", 1, OP_OR, RS_LOGIC, 32'hAAAA_0000, 32'h0000_BEEF, 5'd3, 1), 1'b0);

        // fwd[1] now targets r2
        set_fwd(1, 1, 5'd2, 32'h1111_1111, 0);
        step(mk("or_fwd1", 1, OP_OR, RS_LOGIC, 32'hAAAA_0000, 32'h1111_1111, 5'd3, 1), 1'b0);

        // OR r4,r0,r2: writes to r0 never forwarded and never stall
        inst = 32'h0002_2025;
        set_fwd(0, 1, 5'd0, 32'hFFFF_FFFF, 0);
        set_fwd(1, 1, 5'd0, 32'h5555_5555, 1);
        step(mk("or_r0", 1, OP_OR, RS_LOGIC, 32'h0, 32'h0000_BEEF, 5'd4, 1), 1'b0);
        clr_fwd();

        // NOR r3,r1,r2 from regfile
        inst = 32'h0022_1827;
        step(mk("nor", 1, OP_NOR, RS_LOGIC, 32'h1234_0000, 32'h0000_BEEF, 5'd3, 1), 1'b0);

        // ANDI r5,r6,1 with a load to r6 in EX
        inst = 32'h30C5_0001; reg1_data = 32'h0000_0055;
        set_fwd(0, 1, 5'd6, 32'h0, 1);
        step(bubble("lu_stall"), 1'b1);
        // load moved to fwd[1], data now ready
        clr_fwd();
        set_fwd(1, 1, 5'd6, 32'h0000_0007, 0);
        step(mk("lu_go", 1, OP_AND, RS_LOGIC, 32'h7, 32'h1, 5'd5, 1), 1'b0);

        // Older non-load match does not mask a younger load
        set_fwd(0, 1, 5'd6, 32'h0, 1);
        set_fwd(1, 1, 5'd6, 32'h0000_0009, 0);
        step(bubble("lu_mask"), 1'b1);
        // Younger ready value shadows an older load
        set_fwd(0, 1, 5'd6, 32'h0000_0009, 0);
        set_fwd(1, 1, 5'd6, 32'h0, 1);
        step(mk("lu_shadow", 1, OP_AND, RS_LOGIC, 32'h9, 32'h1, 5'd5, 1), 1'b0);
        clr_fwd();

        // LUI r7,0xBEEF then EX stall, then flush during stall
        inst = 32'h3C07_BEEF;
        #1;
        cmp("lui.reg1_read", 32'(reg1_read), 32'h0);
        step(mk("lui", 1, OP_OR, RS_LOGIC, 32'hBEEF_0000, 32'hBEEF_0000, 5'd7, 1), 1'b0);
        inst = 32'h3422_00FF; ex_stall = 1'b1;
        step(held("hold1"), 1'b0);
        step(held("hold2"), 1'b0);
        flush = 1'b1;
        step(bubble("flush"), 1'b0);
        flush = 1'b0; ex_stall = 1'b0;

        // SLL r8,r9,4 and SRA r8,r9,31
        inst = 32'h0009_4100; reg2_data = 32'h0000_F00F;
        step(mk("sll", 1, OP_SLL, RS_SHIFT, 32'd4, 32'h0000_F00F, 5'd8, 1), 1'b0);
        inst = 32'h0009_47C3;
        step(mk("sra", 1, OP_SRA, RS_SHIFT, 32'd31, 32'h0000_F00F, 5'd8, 1), 1'b0);

        // Unknown opcode: valid NOP
        inst = 32'hFC22_1825;
        step(mk("unk", 1, OP_NOP, RS_NOP, 32'h0, 32'h0, 5'd0, 0), 1'b0);

        // ORI r0,r1,5: wreg suppressed for r0 destination
        inst = 32'h3420_0005; reg1_data = 32'h0000_0100;
        step(mk("ori_r0", 1, OP_OR, RS_LOGIC, 32'h100, 32'h5, 5'd0, 0), 1'b0);

        // Invalid slot: bubble, no reads
        inst_valid = 1'b0; inst = 32'h30C5_0001;
        set_fwd(0, 1, 5'd6, 32'h0, 1);
        step(bubble("invalid"), 1'b0);
        clr_fwd();
        inst_valid = 1'b1;

`ifdef ID_STALL_CNT_EN
        // 5 load-use cycles, 2 of them with EX stalled
        cnt0 = stall_cnt;
        inst = 32'h30C5_0001;
        set_fwd(0, 1, 5'd6, 32'h0, 1);
        step(bubble("cnt1"), 1'b1);
        ex_stall = 1'b1;
        step(held("cnt2"), 1'b1);
        step(held("cnt3"), 1'b1);
        ex_stall = 1'b0;
        step(bubble("cnt4"), 1'b1);
        step(bubble("cnt5"), 1'b1);
        cmp("stall_cnt.delta", stall_cnt - cnt0, 32'd3);
        clr_fwd();
`endif

        inst_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        cmp("scoreboard.drained", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
